daq_event_builder: RTL and testbench

- Transmit-side formatter that feeds the AMC13 DAQ link event port (valid/header/trailer/64-bit data, Ready, AlmostFull).
- Consumes a 32-bit AXI4-Stream frame (one frame per event, tlast marks the end) on the 125 MHz IPbus clock.
- Wraps each frame into a CDF-style event: one 64-bit header, the packed payload, one 64-bit trailer.
- Sits between the IPbus AXI-Stream output and the DAQ link, in place of the loopback FIFO path.

---
 rtl/daq_pkg.sv | 18 +
 rtl/daq_event_builder_if.sv | 21 ++
 rtl/daq_crc16_64.sv | 22 ++
 rtl/daq_event_builder.sv | 122 ++++++++++++
 tb/tb_daq_event_builder.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/daq_pkg.sv
// daq_pkg: shared states, CDF framing constants and CRC-16-CCITT constants for the DAQ event builder
package daq_pkg;
  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, DRAIN, TRAILER} state_t;
  localparam logic [3:0] BOE = 4'h5;
  localparam logic [3:0] EOE = 4'hA;
  localparam int EVT_W = 24;
  localparam int LEN_W = 24;
  localparam int SRC_W = 12;
  localparam int CRC_W = 16;
  localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;
  localparam logic [CRC_W-1:0] CRC_INIT = 16'hFFFF;
  function automatic logic [63:0] mk_header(input logic [EVT_W-1:0] evt, input logic [SRC_W-1:0] src);
    return {BOE, 4'h0, evt, 12'h000, src, 8'h00};
  endfunction
  function automatic logic [63:0] mk_trailer(input logic [LEN_W-1:0] len, input logic [CRC_W-1:0] crc, input logic trunc);
    return {EOE, 4'h0, len, crc, 15'h0, trunc};
  endfunction
endpackage

// File: rtl/daq_event_builder_if.sv
// daq_event_builder_if: 32-bit AXI-Stream input plus DAQ link event port
interface daq_event_builder_if;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tlast;
  logic        daq_valid;
  logic        daq_header;
  logic        daq_trailer;
  logic [63:0] daq_data;
  logic        daq_ready;
  logic        daq_almost_full;
  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tlast, daq_ready, daq_almost_full,
    input  s_axis_tready, daq_valid, daq_header, daq_trailer, daq_data
  );
  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, daq_ready, daq_almost_full,
    output s_axis_tready, daq_valid, daq_header, daq_trailer, daq_data
  );
endinterface

// File: rtl/daq_crc16_64.sv
// daq_crc16_64: CRC-16-CCITT accumulator consuming one 64-bit word per cycle, MSB first
module daq_crc16_64
  import daq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [63:0]      data,
  output logic [CRC_W-1:0] crc
);
  logic [CRC_W-1:0] crc_q, crc_d, step;
  always_comb begin
    step = crc_q;
    for (int i = 63; i >= 0; i--) step = {step[CRC_W-2:0], 1'b0} ^ ((step[CRC_W-1] ^ data[i]) ? CRC_POLY : '0);
    crc_d = clr ? CRC_INIT : en ? step : crc_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) crc_q <= CRC_INIT;
    else crc_q <= crc_d;
  assign crc = crc_q;
endmodule

// File: rtl/daq_event_builder.sv
// daq_event_builder: wraps AXI-Stream frames into header/payload/trailer events for the DAQ link.
// Define DAQ_EVENT_BUILDER_CRC_EN to fill trailer bits [31:16] with a CRC-16-CCITT.
module daq_event_builder
  import daq_pkg::*;
#(
  parameter logic [SRC_W-1:0] SOURCE_ID   = 12'h000,
  parameter int               MAX_PAYLOAD = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  daq_event_builder_if.slave    bus,
  output logic [EVT_W-1:0]      evt_count,
  output logic                  truncated
);
  state_t state_q, state_d;
  logic hi_q, hi_d, trunc_q, trunc_d;
  logic [31:0] lo_q, lo_d;
  logic [LEN_W-1:0] pcnt_q, pcnt_d;
  logic [EVT_W-1:0] evt_q, evt_d;
  logic valid_q, valid_d, header_q, header_d, trailer_q, trailer_d, truncated_q, truncated_d;
  logic [63:0] data_q, data_d;
  logic [CRC_W-1:0] crc;
  logic ok, hs;
  assign ok = bus.daq_ready & ~bus.daq_almost_full;
  assign bus.s_axis_tready = (state_q == DRAIN) || (state_q == PAYLOAD && ok);
  assign hs = bus.s_axis_tvalid & bus.s_axis_tready;
  always_comb begin
    state_d = state_q;
    hi_d = hi_q;
    trunc_d = trunc_q;
    lo_d = lo_q;
    pcnt_d = pcnt_q;
    evt_d = evt_q;
    valid_d = 1'b0;
    header_d = 1'b0;
    trailer_d = 1'b0;
    truncated_d = 1'b0;
    data_d = '0;
    case (state_q)
      IDLE: if (bus.s_axis_tvalid && ok) state_d = HEADER;
      HEADER: if (ok) begin
        valid_d = 1'b1;
        header_d = 1'b1;
        data_d = mk_header(evt_q, SOURCE_ID);
        state_d = PAYLOAD;
      end
      PAYLOAD: if (hs) begin
        if (!hi_q && !bus.s_axis_tlast) begin
          lo_d = bus.s_axis_tdata;
          hi_d = 1'b1;
        end else begin
          // a tlast on the low lane closes the word with a zero high half
          valid_d = 1'b1;
          data_d = hi_q ? {bus.s_axis_tdata, lo_q} : {32'h0, bus.s_axis_tdata};
          pcnt_d = pcnt_q + 1'b1;
          hi_d = 1'b0;
          if (bus.s_axis_tlast) state_d = TRAILER;
          else if (pcnt_d == LEN_W'(MAX_PAYLOAD)) begin
            trunc_d = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: if (hs && bus.s_axis_tlast) state_d = TRAILER;
      TRAILER: if (ok) begin
        valid_d = 1'b1;
        trailer_d = 1'b1;
        data_d = mk_trailer(pcnt_q + LEN_W'(2), crc, trunc_q);
        evt_d = evt_q + 1'b1;
        truncated_d = trunc_q;
        trunc_d = 1'b0;
        pcnt_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      hi_q <= 1'b0;
      trunc_q <= 1'b0;
      lo_q <= '0;
      pcnt_q <= '0;
      evt_q <= '0;
      valid_q <= 1'b0;
      header_q <= 1'b0;
      trailer_q <= 1'b0;
      truncated_q <= 1'b0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      hi_q <= hi_d;
      trunc_q <= trunc_d;
      lo_q <= lo_d;
      pcnt_q <= pcnt_d;
      evt_q <= evt_d;
      valid_q <= valid_d;
      header_q <= header_d;
      trailer_q <= trailer_d;
      truncated_q <= truncated_d;
      data_q <= data_d;
    end
`ifdef DAQ_EVENT_BUILDER_CRC_EN
  daq_crc16_64 u_crc (
    .clk   (clk),
    .reset (reset),
    .clr   (trailer_d),
    .en    (valid_d & ~trailer_d),
    .data  (data_d),
    .crc   (crc)
  );
`else
  assign crc = '0;
`endif
  assign bus.daq_valid = valid_q;
  assign bus.daq_header = header_q;
  assign bus.daq_trailer = trailer_q;
  assign bus.daq_data = data_q;
  assign evt_count = evt_q;
  assign truncated = truncated_q;
endmodule

// File: tb/tb_daq_event_builder.sv
// tb_daq_event_builder: scoreboard bench; dut_a has MAX_PAYLOAD=16, dut_b has MAX_PAYLOAD=2, sel picks one
module tb_daq_event_builder;
  logic clk = 1'b0, reset = 1'b1, sel = 1'b0;
  logic tvalid = 1'b0, tlast = 1'b0, ready = 1'b1, afull = 1'b0;
  logic [31:0] tdata = '0;
  logic [31:0] frm[$];
  logic [65:0] exp_q[$];
  logic [65:0] mon_got, mon_exp;
  int checks = 0, errors = 0, words = 0, trunc_seen = 0, waits = 0;
  int evt_m[2] = '{0, 0};
  logic [23:0] eca, ecb, ec;
  logic tra, trb, tr, tready, dv, dh, dt;
  logic [63:0] dd;

  daq_event_builder_if ifa();
  daq_event_builder_if ifb();
  assign ifa.s_axis_tvalid = tvalid & ~sel;
  assign ifb.s_axis_tvalid = tvalid & sel;
  assign ifa.s_axis_tdata = tdata;
  assign ifb.s_axis_tdata = tdata;
  assign ifa.s_axis_tlast = tlast;
  assign ifb.s_axis_tlast = tlast;
  assign ifa.daq_ready = ready;
  assign ifb.daq_ready = ready;
  assign ifa.daq_almost_full = afull;
  assign ifb.daq_almost_full = afull;
  assign tready = sel ? ifb.s_axis_tready : ifa.s_axis_tready;
  assign dv = sel ? ifb.daq_valid : ifa.daq_valid;
  assign dh = sel ? ifb.daq_header : ifa.daq_header;
  assign dt = sel ? ifb.daq_trailer : ifa.daq_trailer;
  assign dd = sel ? ifb.daq_data : ifa.daq_data;
  assign ec = sel ? ecb : eca;
  assign tr = sel ? trb : tra;

  daq_event_builder #(.SOURCE_ID(12'hABC), .MAX_PAYLOAD(16)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa), .evt_count(eca), .truncated(tra));
  daq_event_builder #(.SOURCE_ID(12'hABC), .MAX_PAYLOAD(2)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb), .evt_count(ecb), .truncated(trb));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired before the end of the run");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [63:0] w);
    for (int b = 7; b >= 0; b--) begin
      c = c ^ {w[b*8 +: 8], 8'h00};
      for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  always @(negedge clk) begin
    if (!reset && dv) begin
      checks++;
      mon_got = {dh, dt, dd};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL daq_word got %h required none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL daq_word got %h required %h", mon_got, mon_exp);
        end
      end
      words++;
    end
    if (!reset && !dv) begin
      checks++;
      if ((dh | dt) !== 1'b0) begin
        errors++;
        $display("FAIL marker_without_valid got h=%b t=%b required 0", dh, dt);
      end
    end
    if (!reset && tr) trunc_seen++;
  end

  task automatic expect_frame();
    int mx = sel ? 2 : 16;
    int np = 0;
    logic [15:0] c = 16'hFFFF;
    logic [63:0] w;
    logic trunc;
    w = {4'h5, 4'h0, 24'(evt_m[sel]), 12'h000, 12'hABC, 8'h00};
    exp_q.push_back({2'b10, w});
    c = crc_ref(c, w);
    for (int i = 0; i < frm.size() && np < mx; i += 2) begin
      w = {(i + 1 < frm.size()) ? frm[i+1] : 32'h0, frm[i]};
      exp_q.push_back({2'b00, w});
      c = crc_ref(c, w);
      np++;
    end
    trunc = (2 * np) < frm.size();
`ifndef DAQ_EVENT_BUILDER_CRC_EN
    c = 16'h0;
`endif
    w = {4'hA, 4'h0, 24'(np + 2), c, 15'h0, trunc};
    exp_q.push_back({2'b01, w});
    evt_m[sel] = evt_m[sel] + 1;
  endtask

  task automatic drive_frame(input int n);
    logic got;
    for (int i = 0; i < n; i++) begin
      tvalid = 1'b1;
      tdata = frm[i];
      tlast = (i == frm.size() - 1);
      got = 1'b0;
      for (int c = 0; c < 300 && !got; c++) begin
        @(negedge clk);
        got = tready;
        if (!got) waits++;
        @(posedge clk);
        #1;
      end
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL handshake word %0d got tready=0 required 1", i);
      end
    end
    tvalid = 1'b0;
    tlast = 1'b0;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 500 && exp_q.size() != 0; c++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({dv, dh, dt, tr} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b required 0000", {dv, dh, dt, tr}); end
    checks++;
    if (dd !== 64'h0) begin errors++; $display("FAIL reset_data got %h required 0", dd); end
    checks++;
    if (ec !== 24'h0) begin errors++; $display("FAIL reset_evt_count got %0d required 0", ec); end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (tready !== 1'b0) begin errors++; $display("FAIL idle_tready got %b required 0", tready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    sel = 1'b0;
    frm = '{32'h11, 32'h22, 32'h33, 32'h44};
    expect_frame();
    drive_frame(frm.size());
    wait_drain();
    checks++;
    if (ec !== 24'd1) begin errors++; $display("FAIL basic_evt_count got %0d required 1", ec); end
  endtask

  task automatic test_odd();
    frm = '{32'hA, 32'hB, 32'hC};
    expect_frame();
    drive_frame(frm.size());
    wait_drain();
    checks++;
    if (ec !== 24'd2) begin errors++; $display("FAIL odd_evt_count got %0d required 2", ec); end
  endtask

  task automatic test_stall();
    frm = '{32'h101, 32'h202, 32'h303, 32'h404, 32'h505, 32'h606, 32'h707, 32'h808};
    expect_frame();
    fork
      drive_frame(frm.size());
      begin
        int base = words;
        for (int c = 0; c < 100 && words < base + 2; c++) begin
          @(negedge clk);
          #1;
        end
        @(posedge clk);
        #1 afull = 1'b1;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          checks++;
          if (tready !== 1'b0) begin errors++; $display("FAIL stall_tready cycle %0d got %b required 0", c, tready); end
          if (c > 0) begin
            checks++;
            if (dv !== 1'b0) begin errors++; $display("FAIL stall_valid cycle %0d got %b required 0", c, dv); end
          end
        end
        @(posedge clk);
        #1 afull = 1'b0;
      end
    join
    wait_drain();
    checks++;
    if (ec !== 24'd3) begin errors++; $display("FAIL stall_evt_count got %0d required 3", ec); end
  endtask

  task automatic test_single();
    frm = '{32'hDEADBEEF};
    expect_frame();
    drive_frame(1);
    wait_drain();
    checks++;
    if (ec !== 24'd4) begin errors++; $display("FAIL single_evt_count got %0d required 4", ec); end
  endtask

  task automatic test_truncation();
    int t0 = trunc_seen;
    sel = 1'b1;
    waits = 0;
    frm = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8, 32'h9, 32'h10};
    expect_frame();
    fork
      drive_frame(frm.size());
      begin
        int base = words;
        for (int c = 0; c < 100 && words < base + 3; c++) begin
          @(negedge clk);
          #1;
        end
        @(posedge clk);
        #1 ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 ready = 1'b1;
      end
    join
    wait_drain();
    checks++;
    if (waits !== 2) begin errors++; $display("FAIL drain_waits got %0d required 2", waits); end
    checks++;
    if (trunc_seen - t0 !== 1) begin errors++; $display("FAIL truncated_pulses got %0d required 1", trunc_seen - t0); end
    checks++;
    if (ec !== 24'd1) begin errors++; $display("FAIL trunc_evt_count got %0d required 1", ec); end
  endtask

  task automatic test_back_to_back();
    int t0 = trunc_seen;
    frm = '{32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003};
    expect_frame();
    drive_frame(frm.size());
    frm = '{32'hBEEF0001, 32'hBEEF0002};
    expect_frame();
    drive_frame(frm.size());
    wait_drain();
    checks++;
    if (ec !== 24'd3) begin errors++; $display("FAIL b2b_evt_count got %0d required 3", ec); end
    checks++;
    if (trunc_seen !== t0) begin errors++; $display("FAIL b2b_truncated got %0d required %0d", trunc_seen, t0); end
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    frm = '{32'h55, 32'h66};
    expect_frame();
    drive_frame(frm.size());
    wait_drain();
    checks++;
    if (ec !== 24'd5) begin errors++; $display("FAIL pre_reset_evt_count got %0d required 5", ec); end
    frm = '{32'hF1, 32'hF2, 32'hF3, 32'hF4, 32'hF5, 32'hF6};
    exp_q.push_back({2'b10, 4'h5, 4'h0, 24'(evt_m[0]), 12'h000, 12'hABC, 8'h00});
    exp_q.push_back({2'b00, frm[1], frm[0]});
    drive_frame(2);
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) begin
      @(negedge clk);
      #1;
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({dv, dh, dt} !== 3'b0) begin errors++; $display("FAIL async_reset_flags got %b required 000", {dv, dh, dt}); end
    checks++;
    if (dd !== 64'h0) begin errors++; $display("FAIL async_reset_data got %h required 0", dd); end
    checks++;
    if (ec !== 24'h0) begin errors++; $display("FAIL async_reset_evt_count got %0d required 0", ec); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL partial_words got %0d pending required 0", exp_q.size()); end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    evt_m[0] = 0;
    repeat (3) @(posedge clk);
    #1;
    frm = '{32'h77};
    expect_frame();
    drive_frame(1);
    wait_drain();
    checks++;
    if (ec !== 24'd1) begin errors++; $display("FAIL post_reset_evt_count got %0d required 1", ec); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_odd();
    test_stall();
    test_single();
    test_truncation();
    test_back_to_back();
    test_reset_mid();
    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
